ext_mmio_responder: RTL and testbench

- Bus responder on the `mips_system` external data bus. It consumes the core's ext_write_en, ext_read_en, ext_addr and ext_write_data, and drives the word the core samples as ext_data_in.
- It implements a small memory-mapped peripheral set: GPIO out/in, a 32-bit compare timer with interrupt, and a byte TX FIFO with a valid/ready output stream.
- It sits beside `mips_system` at top level and replaces the constant-zero ext_data_in the bench drives today.

---
 rtl/ext_mmio_pkg.sv | 28 ++
 rtl/ext_tx_fifo.sv | 65 ++++++
 rtl/ext_mmio_responder.sv | 141 ++++++++++++++
 tb/tb_ext_mmio_responder.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_mmio_pkg.sv
// Register map, control/status bit positions and field widths for the
// external-bus MMIO responder.
package ext_mmio_pkg;

  localparam logic [31:0] OFS_GPIO_OUT  = 32'h00;
  localparam logic [31:0] OFS_GPIO_IN   = 32'h04;
  localparam logic [31:0] OFS_TMR_COUNT = 32'h08;
  localparam logic [31:0] OFS_TMR_CTRL  = 32'h0C;
  localparam logic [31:0] OFS_TMR_CMP   = 32'h10;
  localparam logic [31:0] OFS_STATUS    = 32'h14;
  localparam logic [31:0] OFS_TX_DATA   = 32'h18;

  localparam int CTRL_EN          = 0;
  localparam int CTRL_AUTO_RELOAD = 1;
  localparam int CTRL_IRQ_EN      = 2;
  localparam int CTRL_W           = 3;

  localparam int ST_MATCH      = 0;
  localparam int ST_FIFO_FULL  = 1;
  localparam int ST_FIFO_EMPTY = 2;
  localparam int ST_TX_OVF     = 3;
  localparam int ST_CNT_LSB    = 7;
  localparam int ST_CNT_W      = 5;

  localparam int BUS_W = 32;
  localparam int TX_W  = 8;

endpackage

// File: rtl/ext_tx_fifo.sv
// Byte FIFO feeding the TX stream; pointers carry one extra wrap bit so that
// full and empty are distinguishable without a separate counter.
module ext_tx_fifo
  import ext_mmio_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [TX_W-1:0]        push_data,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [TX_W-1:0]        head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic [TX_W-1:0] mem_q [DEPTH];
  logic [TX_W-1:0] mem_d [DEPTH];
  logic            push_ok;
  logic            pop_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count   = wr_ptr_q - rd_ptr_q;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage holds data only; emptiness is decided by the pointers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/ext_mmio_responder.sv
// Zero-wait-state MMIO responder on the core's external data bus: GPIO,
// compare timer with interrupt, and a byte TX FIFO with valid/ready output.
module ext_mmio_responder
  import ext_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
  parameter int          OFS_W      = 8,
  parameter int          GPIO_W     = 8,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ext_write_en,
  input  logic              ext_read_en,
  input  logic [BUS_W-1:0]  ext_addr,
  input  logic [BUS_W-1:0]  ext_write_data,
  output logic [BUS_W-1:0]  ext_read_data,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              tx_valid,
  output logic [TX_W-1:0]   tx_data,
  input  logic              tx_ready,
  output logic              irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic              in_win;
  logic [31:0]       ofs;
  logic              wr_gpio, wr_cnt, wr_ctrl, wr_cmp, wr_st, wr_tx;
  logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
  logic [GPIO_W-1:0] gpio_sync1_q, gpio_sync2_q;
  logic [31:0]       tmr_count_q, tmr_count_d;
  logic [31:0]       tmr_cmp_q, tmr_cmp_d;
  logic [CTRL_W-1:0] tmr_ctrl_q, tmr_ctrl_d;
  logic              match_q, match_d;
  logic              ovf_q, ovf_d;
  logic              irq_q, irq_d;
  logic              tmr_hit;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [31:0]       status;

  assign in_win  = (ext_addr[31:OFS_W] == BASE_ADDR[31:OFS_W]);
  assign ofs     = 32'(ext_addr[OFS_W-1:0]) & ~32'h3;
  assign wr_gpio = ext_write_en && in_win && (ofs == OFS_GPIO_OUT);
  assign wr_cnt  = ext_write_en && in_win && (ofs == OFS_TMR_COUNT);
  assign wr_ctrl = ext_write_en && in_win && (ofs == OFS_TMR_CTRL);
  assign wr_cmp  = ext_write_en && in_win && (ofs == OFS_TMR_CMP);
  assign wr_st   = ext_write_en && in_win && (ofs == OFS_STATUS);
  assign wr_tx   = ext_write_en && in_win && (ofs == OFS_TX_DATA);

  assign tmr_hit = tmr_ctrl_q[CTRL_EN] && (tmr_count_q == tmr_cmp_q);

  always_comb begin
    gpio_out_d  = wr_gpio ? ext_write_data[GPIO_W-1:0] : gpio_out_q;
    tmr_cmp_d   = wr_cmp ? ext_write_data : tmr_cmp_q;
    tmr_ctrl_d  = wr_ctrl ? ext_write_data[CTRL_W-1:0] : tmr_ctrl_q;
    tmr_count_d = tmr_count_q;
    if (tmr_ctrl_q[CTRL_EN]) begin
      tmr_count_d = (tmr_hit && tmr_ctrl_q[CTRL_AUTO_RELOAD]) ? '0 : tmr_count_q + 32'd1;
    end
    if (wr_cnt) begin
      tmr_count_d = ext_write_data;
    end
    // Sticky flags: clear first so a same-cycle set takes priority.
    match_d = match_q;
    if (wr_st && ext_write_data[ST_MATCH]) match_d = 1'b0;
    if (tmr_hit) match_d = 1'b1;
    ovf_d = ovf_q;
    if (wr_st && ext_write_data[ST_TX_OVF]) ovf_d = 1'b0;
    if (wr_tx && fifo_full) ovf_d = 1'b1;
    irq_d = match_d && tmr_ctrl_d[CTRL_IRQ_EN];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_out_q   <= '0;
      gpio_sync1_q <= '0;
      gpio_sync2_q <= '0;
      tmr_count_q  <= '0;
      tmr_cmp_q    <= '0;
      tmr_ctrl_q   <= '0;
      match_q      <= 1'b0;
      ovf_q        <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      gpio_out_q   <= gpio_out_d;
      gpio_sync1_q <= gpio_in;
      gpio_sync2_q <= gpio_sync1_q;
      tmr_count_q  <= tmr_count_d;
      tmr_cmp_q    <= tmr_cmp_d;
      tmr_ctrl_q   <= tmr_ctrl_d;
      match_q      <= match_d;
      ovf_q        <= ovf_d;
      irq_q        <= irq_d;
    end
  end

  ext_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_tx),
    .push_data (ext_write_data[TX_W-1:0]),
    .pop       (tx_ready),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (tx_data)
  );

  always_comb begin
    status                = 32'(fifo_count) << ST_CNT_LSB;
    status[ST_MATCH]      = match_q;
    status[ST_FIFO_FULL]  = fifo_full;
    status[ST_FIFO_EMPTY] = fifo_empty;
    status[ST_TX_OVF]     = ovf_q;
  end

  always_comb begin
    ext_read_data = '0;
    if (ext_read_en && in_win) begin
      case (ofs)
        OFS_GPIO_OUT:  ext_read_data = 32'(gpio_out_q);
        OFS_GPIO_IN:   ext_read_data = 32'(gpio_sync2_q);
        OFS_TMR_COUNT: ext_read_data = tmr_count_q;
        OFS_TMR_CTRL:  ext_read_data = 32'(tmr_ctrl_q);
        OFS_TMR_CMP:   ext_read_data = tmr_cmp_q;
        OFS_STATUS:    ext_read_data = status;
        default:       ext_read_data = '0;
      endcase
    end
  end

  assign gpio_out = gpio_out_q;
  assign tx_valid = !fifo_empty;
  assign irq      = irq_q;

endmodule

// File: tb/tb_ext_mmio_responder.sv
// Self-checking bench for ext_mmio_responder: register readback, GPIO, timer
// and TX FIFO, with a queue of expected stream bytes.
module tb_ext_mmio_responder;

  localparam logic [31:0] BASE   = 32'hFFFF_0000;
  localparam logic [31:0] A_GPO  = BASE + 32'h00;
  localparam logic [31:0] A_GPI  = BASE + 32'h04;
  localparam logic [31:0] A_CNT  = BASE + 32'h08;
  localparam logic [31:0] A_CTRL = BASE + 32'h0C;
  localparam logic [31:0] A_CMP  = BASE + 32'h10;
  localparam logic [31:0] A_ST   = BASE + 32'h14;
  localparam logic [31:0] A_TX   = BASE + 32'h18;

  logic        clk = 1'b0;
  logic        rst;
  logic        ext_write_en;
  logic        ext_read_en;
  logic [31:0] ext_addr;
  logic [31:0] ext_write_data;
  logic [31:0] ext_read_data;
  logic [7:0]  gpio_in;
  logic [7:0]  gpio_out;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  ext_mmio_responder dut (
    .clk            (clk),
    .rst            (rst),
    .ext_write_en   (ext_write_en),
    .ext_read_en    (ext_read_en),
    .ext_addr       (ext_addr),
    .ext_write_data (ext_write_data),
    .ext_read_data  (ext_read_data),
    .gpio_in        (gpio_in),
    .gpio_out       (gpio_out),
    .tx_valid       (tx_valid),
    .tx_data        (tx_data),
    .tx_ready       (tx_ready),
    .irq            (irq)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    ext_addr       = a;
    ext_write_data = d;
    ext_write_en   = 1'b1;
    step();
    ext_write_en   = 1'b0;
    ext_write_data = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    ext_addr    = a;
    ext_read_en = 1'b1;
    #1;
    d           = ext_read_data;
    ext_read_en = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    if (sb.size() < 8) sb.push_back(b);
    bus_write(A_TX, {24'h0, b});
  endtask

  task automatic test_reset();
    logic [31:0] r;
    logic [31:0] exp_rd [8] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h0, 32'h0};
    rst = 1'b1;
    ext_write_en = 1'b0; ext_read_en = 1'b0; ext_addr = '0; ext_write_data = '0;
    gpio_in = '0; tx_ready = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    for (int i = 0; i < 8; i++) begin
      bus_read(BASE + 32'(i * 4), r);
      n_checks++;
      if (r !== exp_rd[i]) begin
        n_fail++;
        $display("FAIL reset_read ofs=%0h: got %h expected %h", i * 4, r, exp_rd[i]);
      end
    end
    bus_read(32'h0000_1000, r);
    n_checks++;
    if (r !== 32'h0) begin n_fail++; $display("FAIL out_of_window_read: got %h expected 0", r); end
    bus_read(32'hFFFE_0014, r);
    n_checks++;
    if (r !== 32'h0) begin n_fail++; $display("FAIL near_window_read: got %h expected 0", r); end
    ext_addr = A_ST; ext_read_en = 1'b0; #1;
    n_checks++;
    if (ext_read_data !== 32'h0) begin n_fail++; $display("FAIL idle_read: got %h expected 0", ext_read_data); end
    n_checks++;
    if (tx_valid !== 1'b0 || irq !== 1'b0 || gpio_out !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b irq=%b gpio=%h expected 0/0/00", tx_valid, irq, gpio_out);
    end
  endtask

  task automatic test_gpio();
    logic [31:0] r;
    bus_write(A_GPO, 32'h0000_00A5);
    n_checks++;
    if (gpio_out !== 8'hA5) begin n_fail++; $display("FAIL gpio_out: got %h expected a5", gpio_out); end
    bus_read(A_GPO, r);
    n_checks++;
    if (r !== 32'hA5) begin n_fail++; $display("FAIL gpio_out_read: got %h expected a5", r); end
    gpio_in = 8'h3C;
    step();
    bus_read(A_GPI, r);
    n_checks++;
    if (r !== 32'h0) begin n_fail++; $display("FAIL gpio_in_lat1: got %h expected 0", r); end
    step();
    bus_read(A_GPI, r);
    n_checks++;
    if (r !== 32'h3C) begin n_fail++; $display("FAIL gpio_in_lat2: got %h expected 3c", r); end
    // Same-cycle read and write of GPIO_OUT.
    ext_addr = A_GPO; ext_write_data = 32'h5A; ext_write_en = 1'b1; ext_read_en = 1'b1;
    #1;
    r = ext_read_data;
    n_checks++;
    if (r !== 32'hA5) begin n_fail++; $display("FAIL gpio_rw_same_cycle: got %h expected a5", r); end
    step();
    ext_write_en = 1'b0; ext_read_en = 1'b0;
    n_checks++;
    if (gpio_out !== 8'h5A) begin n_fail++; $display("FAIL gpio_rw_commit: got %h expected 5a", gpio_out); end
  endtask

  task automatic test_timer_reload();
    logic [31:0] r;
    logic [31:0] exp_cnt [8] = '{0, 1, 2, 3, 4, 5, 0, 1};
    logic        exp_m   [8] = '{0, 0, 0, 0, 0, 0, 1, 1};
    bus_write(A_CMP, 32'd5);
    bus_write(A_CNT, 32'd0);
    bus_write(A_CTRL, 32'h7);
    for (int i = 0; i < 8; i++) begin
      bus_read(A_CNT, r);
      n_checks++;
      if (r !== exp_cnt[i]) begin n_fail++; $display("FAIL reload_count[%0d]: got %h expected %h", i, r, exp_cnt[i]); end
      bus_read(A_ST, r);
      n_checks++;
      if (r[0] !== exp_m[i] || irq !== exp_m[i]) begin
        n_fail++;
        $display("FAIL reload_match[%0d]: got match=%b irq=%b expected %b", i, r[0], irq, exp_m[i]);
      end
      if (i < 7) step();
    end
    bus_write(A_ST, 32'h1);
    bus_read(A_CNT, r);
    n_checks++;
    if (irq !== 1'b0 || r !== 32'd2) begin n_fail++; $display("FAIL w1c_match: got irq=%b count=%h expected 0/2", irq, r); end
    repeat (3) step();
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_before_rematch: got %b expected 0", irq); end
    step();
    bus_read(A_ST, r);
    n_checks++;
    if (irq !== 1'b1 || r[0] !== 1'b1) begin n_fail++; $display("FAIL rematch: got irq=%b match=%b expected 1/1", irq, r[0]); end
    bus_write(A_CTRL, 32'h0);
    bus_write(A_ST, 32'h1);
    bus_read(A_CTRL, r);
    n_checks++;
    if (irq !== 1'b0 || r !== 32'h0) begin n_fail++; $display("FAIL timer_stop: got irq=%b ctrl=%h expected 0/0", irq, r); end
  endtask

  task automatic test_timer_wrap();
    logic [31:0] r;
    logic [31:0] exp_cnt [8] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 0, 1, 2, 3, 4, 5};
    logic        exp_m   [8] = '{0, 0, 0, 0, 0, 0, 1, 1};
    bus_write(A_CMP, 32'd3);
    bus_write(A_CNT, 32'hFFFF_FFFE);
    bus_write(A_CTRL, 32'h1);
    for (int i = 0; i < 8; i++) begin
      bus_read(A_CNT, r);
      n_checks++;
      if (r !== exp_cnt[i]) begin n_fail++; $display("FAIL wrap_count[%0d]: got %h expected %h", i, r, exp_cnt[i]); end
      bus_read(A_ST, r);
      n_checks++;
      if (r[0] !== exp_m[i] || irq !== 1'b0) begin
        n_fail++;
        $display("FAIL wrap_match[%0d]: got match=%b irq=%b expected %b/0", i, r[0], irq, exp_m[i]);
      end
      if (i < 7) step();
    end
    bus_write(A_CTRL, 32'h0);
    bus_write(A_ST, 32'h1);
  endtask

  task automatic test_fifo_overflow();
    logic [31:0] r;
    int          n;
    tx_ready = 1'b0;
    for (int b = 8'h10; b <= 8'h18; b++) push_byte(8'(b));
    bus_read(A_ST, r);
    n_checks++;
    if (r !== 32'h0000_040A) begin n_fail++; $display("FAIL ovf_status: got %h expected 0000040a", r); end
    n_checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h10) begin n_fail++; $display("FAIL full_head: got v=%b d=%h expected 1/10", tx_valid, tx_data); end
    step();
    n_checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h10) begin n_fail++; $display("FAIL stall_stable: got v=%b d=%h expected 1/10", tx_valid, tx_data); end
    tx_ready = 1'b1;
    n = 0;
    while (sb.size() > 0 && n < 20) begin
      n_checks++;
      if (tx_valid !== 1'b1 || tx_data !== sb[0]) begin
        n_fail++;
        $display("FAIL stream_ovf: got v=%b d=%h expected 1/%h", tx_valid, tx_data, sb[0]);
      end
      void'(sb.pop_front());
      step();
      n++;
    end
    tx_ready = 1'b0;
    n_checks++;
    if (n != 8) begin n_fail++; $display("FAIL stream_ovf_len: got %0d expected 8", n); end
    bus_read(A_ST, r);
    n_checks++;
    if (tx_valid !== 1'b0 || r !== 32'h0000_000C) begin n_fail++; $display("FAIL drained_status: got v=%b st=%h expected 0/0000000c", tx_valid, r); end
    bus_write(A_ST, 32'h8);
    bus_read(A_ST, r);
    n_checks++;
    if (r !== 32'h0000_0004) begin n_fail++; $display("FAIL ovf_w1c: got %h expected 00000004", r); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    int          n;
    tx_ready = 1'b0;
    push_byte(8'hA0); push_byte(8'hA1); push_byte(8'hA2);
    bus_read(A_ST, r);
    n_checks++;
    if (r !== 32'h0000_0180) begin n_fail++; $display("FAIL count3_status: got %h expected 00000180", r); end
    n_checks++;
    if (tx_data !== sb[0]) begin n_fail++; $display("FAIL pushpop_head: got %h expected %h", tx_data, sb[0]); end
    void'(sb.pop_front());
    tx_ready = 1'b1;
    push_byte(8'hA3);
    tx_ready = 1'b0;
    bus_read(A_ST, r);
    n_checks++;
    if (r !== 32'h0000_0180) begin n_fail++; $display("FAIL pushpop_count: got %h expected 00000180", r); end
    tx_ready = 1'b1;
    n = 0;
    while (sb.size() > 0 && n < 20) begin
      n_checks++;
      if (tx_valid !== 1'b1 || tx_data !== sb[0]) begin
        n_fail++;
        $display("FAIL stream_order: got v=%b d=%h expected 1/%h", tx_valid, tx_data, sb[0]);
      end
      void'(sb.pop_front());
      step();
      n++;
    end
    tx_ready = 1'b0;
    n_checks++;
    if (tx_valid !== 1'b0 || n != 3) begin n_fail++; $display("FAIL stream_order_end: got v=%b n=%0d expected 0/3", tx_valid, n); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    tx_ready = 1'b0;
    for (int b = 0; b < 4; b++) push_byte(8'(8'hC0 + b));
    n_checks++;
    if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid: got %b expected 1", tx_valid); end
    rst = 1'b1;
    ext_addr = A_GPO; ext_write_data = 32'hFF; ext_write_en = 1'b1;
    step();
    rst = 1'b0; ext_write_en = 1'b0;
    sb.delete();
    bus_read(A_ST, r);
    n_checks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h0 || gpio_out !== 8'h0 || r !== 32'h4) begin
      n_fail++;
      $display("FAIL mid_reset: got v=%b d=%h gpio=%h st=%h expected 0/00/00/00000004", tx_valid, tx_data, gpio_out, r);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_gpio();
    test_timer_reload();
    test_timer_wrap();
    test_fifo_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
